// File: rtl/bram_sdp_burst_reader.sv
// Burst read master for a simple-dual-port BRAM with a one-cycle registered
// read port. Accepts (addr, len) commands, issues sequential reads and
// streams the words out through a 3-entry FIFO with valid/ready and last.
module bram_sdp_burst_reader #(
  parameter int AWIDTH = 9,
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [AWIDTH-1:0] cmd_addr,
  input  logic [AWIDTH:0]   cmd_len,
  output logic              rce,
  output logic [AWIDTH-1:0] ra,
  input  logic [DWIDTH-1:0] rq,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DWIDTH-1:0] m_data,
  output logic              m_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_t;

  state_t            state;
  logic [AWIDTH:0]   len_q;
  logic [AWIDTH:0]   issued;
  logic [AWIDTH:0]   issued_inc;
  logic [AWIDTH-1:0] ra_inc;

  // Read pipeline: rce marks a read registered into the BRAM this cycle,
  // rce_d marks that rq carries its data now. rlast/rlast_d follow them.
  logic rce_d;
  logic rlast;
  logic rlast_d;

  // Shift-register FIFO, entry 0 is the head so outputs come straight off flops.
  logic [DWIDTH-1:0] fifo_data [3];
  logic [2:0]        fifo_last;
  logic [1:0]        fifo_count;

  logic       push;
  logic       pop;
  logic [1:0] count_next;
  logic [1:0] wr_idx;
  logic [2:0] occ_next;
  logic       can_issue;

  assign m_data = fifo_data[0];
  assign m_last = fifo_last[0];

  // Next-cycle FIFO occupancy and the read credit derived from it.
  // NOTE: every always_comb output gets a value on every path, otherwise a latch is inferred.
  always_comb begin
    push       = rce_d;
    pop        = m_valid & m_ready;
    count_next = fifo_count + {1'b0, push} - {1'b0, pop};
    wr_idx     = fifo_count - {1'b0, pop};
    // Entries held after this edge plus the read still in the BRAM after it.
    occ_next   = {1'b0, count_next} + {2'b0, rce};
    can_issue  = (occ_next < 3'd3);
    issued_inc = issued + 1'b1;
    ra_inc     = ra + 1'b1;
  end

  // Command FSM and read issue; all outputs registered.
  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      rce       <= 1'b0;
      ra        <= '0;
      rlast     <= 1'b0;
      len_q     <= '0;
      issued    <= '0;
    end else begin
      rce  <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            if (cmd_len == '0) begin
              done  <= 1'b1;
              state <= FIN;
            end else begin
              // FIFO is empty and nothing is in flight, so the first read goes out now.
              len_q  <= cmd_len;
              rce    <= 1'b1;
              ra     <= cmd_addr;
              issued <= {{AWIDTH{1'b0}}, 1'b1};
              rlast  <= (cmd_len == {{AWIDTH{1'b0}}, 1'b1});
              state  <= RUN;
            end
          end
        end
        RUN: begin
          if (issued == len_q) begin
            state <= DRAIN;
          end else if (can_issue) begin
            rce    <= 1'b1;
            ra     <= ra_inc;
            issued <= issued_inc;
            rlast  <= (issued_inc == len_q);
          end
        end
        DRAIN: begin
          // Finish once nothing is in flight and the last beat leaves this edge.
          if (!rce && !rce_d && count_next == 2'd0) begin
            done  <= 1'b1;
            state <= FIN;
          end
        end
        FIN: begin
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read-return pipeline, FIFO occupancy, valid and last flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rce_d      <= 1'b0;
      rlast_d    <= 1'b0;
      fifo_count <= 2'd0;
      m_valid    <= 1'b0;
      fifo_last  <= 3'b000;
    end else begin
      rce_d      <= rce;
      rlast_d    <= rlast;
      fifo_count <= count_next;
      m_valid    <= (count_next != 2'd0);
      // Clearing the vacated top keeps every last bit above the count at zero.
      if (pop) begin
        fifo_last[0] <= fifo_last[1];
        fifo_last[1] <= fifo_last[2];
        fifo_last[2] <= 1'b0;
      end
      if (push) begin
        fifo_last[wr_idx] <= rlast_d;
      end
    end
  end

  // FIFO data storage, shifted on pop and written at the tail on push.
  // NOTE: data storage is not reset; m_valid and the last bits gate its meaning.
  always_ff @(posedge clk) begin
    if (pop) begin
      fifo_data[0] <= fifo_data[1];
      fifo_data[1] <= fifo_data[2];
    end
    if (push) begin
      fifo_data[wr_idx] <= rq;
    end
  end

endmodule

// File: tb/tb_bram_sdp_burst_reader.sv
// Directed testbench for bram_sdp_burst_reader: BRAM model with mem[i]=i,
// burst runner checking address sequence, data order, last flag, latency,
// backpressure stability, read credit and completion timing.
module tb_bram_sdp_burst_reader;

  localparam int AW = 9;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic [AW:0]   cmd_len;
  logic          rce;
  logic [AW-1:0] ra;
  logic [DW-1:0] rq;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          busy;
  logic          done;

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] mem [1<<AW];

  // Bench view of in-flight reads and FIFO occupancy.
  logic rce_dly;
  int   occ;

  bram_sdp_burst_reader #(.AWIDTH(AW), .DWIDTH(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .rce       (rce),
    .ra        (ra),
    .rq        (rq),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_last    (m_last),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Registered BRAM read port: rq updates only when rce is high.
  always @(posedge clk) begin
    if (rce) rq <= mem[ra];
  end

  // Track FIFO occupancy from pushes (read returns) and pops (handshakes).
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rce_dly <= 1'b0;
      occ     <= 0;
    end else begin
      rce_dly <= rce;
      occ     <= occ + int'(rce_dly) - int'(m_valid && m_ready);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one command and follow it to completion.
  task automatic run_burst(input logic [AW-1:0] addr, input logic [AW:0] len,
                           input bit rand_ready, input bit hold_cmd, input bit check_lat);
    int            beats, issued, cyc, first_cyc, last_cyc;
    bit            prev_stall, got_done;
    logic [DW-1:0] prev_data;
    logic [AW-1:0] exp_a;
    check("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_addr  = addr;
    cmd_len   = len;
    m_ready   = 1'b0;
    step();
    if (!hold_cmd) cmd_valid = 1'b0;
    check("busy_start", busy, 1);
    check("cmd_ready_busy", cmd_ready, 0);
    if (len == 0) begin
      check("zero_done", done, 1);
      check("zero_rce", rce, 0);
      check("zero_valid", m_valid, 0);
      cmd_valid = 1'b0;
      step();
      check("zero_idle_ready", cmd_ready, 1);
      check("zero_done_clear", done, 0);
      check("zero_rce_after", rce, 0);
      return;
    end
    check("first_rce", rce, 1);
    check("first_ra", ra, addr);
    beats = 0; issued = 0; cyc = 1; first_cyc = -1; last_cyc = -1;
    prev_stall = 1'b0; got_done = 1'b0; prev_data = '0;
    while (!got_done && cyc < 2000) begin
      if (rce) begin
        exp_a = addr + issued[AW-1:0];
        check("ra_seq", ra, exp_a);
        issued++;
      end
      check("credit", (occ + int'(rce) + int'(rce_dly)) <= 3, 1);
      if (prev_stall) begin
        check("hold_valid", m_valid, 1);
        check("hold_data", m_data, prev_data);
      end
      if (done) begin
        got_done = 1'b1;
        check("done_timing", cyc, last_cyc + 1);
        check("done_beats", beats, len);
        check("done_valid", m_valid, 0);
        if (hold_cmd) begin
          check("hold_cmd_ready", cmd_ready, 0);
          cmd_valid = 1'b0;
        end
      end else begin
        if (m_valid && first_cyc < 0) first_cyc = cyc;
        if (!rand_ready && first_cyc >= 0 && beats < int'(len)) check("contiguous", m_valid, 1);
        m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        if (m_valid && m_ready) begin
          exp_a = addr + beats[AW-1:0];
          check("data", m_data, mem[exp_a]);
          check("last", m_last, beats == int'(len) - 1);
          beats++;
          if (beats == int'(len)) last_cyc = cyc;
        end
        prev_stall = m_valid && !m_ready;
        prev_data  = m_data;
      end
      step();
      cyc++;
    end
    m_ready = 1'b0;
    if (!got_done) check("done_timeout", 0, 1);
    check("issued", issued, len);
    if (check_lat) check("latency", first_cyc, 3);
    check("idle_ready", cmd_ready, 1);
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);
    check("idle_rce", rce, 0);
    if (hold_cmd) begin
      step();
      check("single_burst", busy, 0);
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = DW'(i);
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_len   = '0;
    m_ready   = 1'b0;
    step();
    step();
    check("rst_rce", rce, 0);
    check("rst_ra", ra, 0);
    check("rst_valid", m_valid, 0);
    check("rst_last", m_last, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    rst_n = 1'b1;
    step();

    run_burst(9'd5, 10'd4, 1'b0, 1'b0, 1'b1);    // basic
    run_burst(9'd0, 10'd16, 1'b1, 1'b0, 1'b0);   // backpressure
    run_burst(9'd510, 10'd4, 1'b0, 1'b0, 1'b1);  // wrap-around
    run_burst(9'd0, 10'd0, 1'b0, 1'b0, 1'b0);    // zero length
    run_burst(9'd100, 10'd8, 1'b0, 1'b1, 1'b1);  // cmd_valid held while busy

    // Mid-burst asynchronous reset with data sitting in the FIFO.
    cmd_valid = 1'b1;
    cmd_addr  = 9'd0;
    cmd_len   = 10'd16;
    m_ready   = 1'b0;
    step();
    cmd_valid = 1'b0;
    step();
    step();
    step();
    check("pre_rst_valid", m_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_rce", rce, 0);
    check("async_rst_valid", m_valid, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_cmd_ready", cmd_ready, 1);
    step();
    rst_n = 1'b1;
    step();
    run_burst(9'd20, 10'd3, 1'b0, 1'b0, 1'b1);   // clean start after reset

    run_burst(9'd0, 10'd512, 1'b0, 1'b0, 1'b1);  // full depth

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bram_sdp_burst_reader.md
Name: bram_sdp_burst_reader

Overview:
Read-side master for a simple-dual-port BRAM. The BRAM has a registered read port: one-cycle latency, with rq updated only when rce=1 and held otherwise. This block accepts a burst command (start address, word count), issues sequential reads on the BRAM read port, and presents the words as a valid/ready stream with a last flag. A 3-entry output FIFO absorbs the read latency so that backpressure never loses data and sustained throughput is 1 word/cycle.

Parameters:
AWIDTH, 9, BRAM address width; memory depth is 2^AWIDTH words.
DWIDTH, 32, BRAM data width and stream data width.

Ports:
clk  input  1  single clock; all logic on posedge.
rst_n  input  1  asynchronous, active-low reset.
cmd_valid  input  1  burst command valid.
cmd_ready  output  1  high when idle and able to accept a command.
cmd_addr  input  AWIDTH  start word address.
cmd_len  input  AWIDTH+1  number of words to read, 0..2^AWIDTH.
rce  output  1  BRAM read enable, registered.
ra  output  AWIDTH  BRAM read address, registered.
rq  input  DWIDTH  BRAM read data; valid in the cycle after rce=1.
m_valid  output  1  stream word valid.
m_ready  input  1  stream consumer ready.
m_data  output  DWIDTH  stream word.
m_last  output  1  marks the final word of the burst; qualified by m_valid.
busy  output  1  a burst is in progress.
done  output  1  one-cycle pulse when a burst completes.

Behaviour:
- Reset (async assert, sync deassert handled externally):
  - state=IDLE, cmd_ready=1, rce=0, ra=0, m_valid=0, m_last=0, busy=0, done=0.
  - FIFO empty, in-flight counter 0.
- States:
  - IDLE: cmd_ready=1.
    - On cmd_valid&cmd_ready with len>0: latch addr/len, go to RUN.
    - On cmd_valid&cmd_ready with len==0: go to FIN.
  - RUN: issue reads until issued count == len, then go to DRAIN.
  - DRAIN: wait until every read has returned and the FIFO is empty, i.e. the last beat has been accepted. Then go to FIN.
  - FIN: done=1 for exactly one cycle, then go to IDLE.
- busy=1 in RUN, DRAIN and FIN. cmd_ready=0 outside IDLE; cmd_valid there is ignored and the command is not queued.
- Read issue:
  - rce=1 for a cycle only while fifo_count + reads_in_flight < 3. This accounting must count the read being registered this edge and any FIFO pop this edge.
  - ra increments by 1 per issued read, modulo 2^AWIDTH (wrap 2^AWIDTH-1 -> 0).
  - rce never depends combinationally on m_ready.
- Capture: rq is pushed into the FIFO only in the cycle immediately after an rce=1 cycle. rq in other cycles is stale and must be ignored.
- FIFO:
  - 3 entries; each entry holds data and a last bit.
  - The last bit is set on the word whose read index == len-1.
  - Registered outputs: m_valid = FIFO not empty; m_data/m_last come from the head entry.
  - A beat transfers on m_valid&m_ready.
  - Simultaneous push and pop keeps the count unchanged.
  - Overflow is impossible by the credit rule; underflow is impossible because pop requires m_valid.
- Stream rules:
  - m_data and m_last stay stable while m_valid&!m_ready.
  - m_valid never drops without a handshake.
- Latency: handshake in cycle 0 -> rce=1, ra=addr in cycle 1 -> rq valid in cycle 2 -> m_valid=1 in cycle 3.
- Throughput: with m_ready held high, the burst has no bubbles after the first beat.
- Completion: done pulses the cycle after the last-beat handshake, and cmd_ready returns the cycle after that. With len==0, done pulses in cycle 1 and no beat is produced.
- Mid-burst reset: all state is cleared immediately, in-flight data is discarded, and the FIFO contents are lost.
- cmd_len > 2^AWIDTH: not representable in cmd_len, so no check is needed.

Test Plan:
- Reset: assert rst_n=0 mid-run -> rce=0, m_valid=0, busy=0 and cmd_ready=1 immediately, asynchronously. After release, a new command starts cleanly.
- Basic burst: memory[i]=i, AWIDTH=9, addr=5, len=4, m_ready=1 -> first m_valid 3 cycles after the handshake; data 5,6,7,8 on consecutive cycles; m_last on 8; done one cycle later.
- Backpressure: addr=0, len=16, m_ready toggled pseudo-randomly (50%) -> exactly 16 beats 0..15 in order, no duplicates or drops. rce is never high while fifo_count + in-flight == 3.
- Wrap-around: AWIDTH=9, addr=510, len=4 -> ra sequence 510,511,0,1; data matches memory; m_last on the word from address 1.
- Zero length and busy guard: cmd len=0 -> done pulse in cycle 1, no m_valid, rce stays 0. cmd_valid held during a len=8 burst -> cmd_ready=0 and only one burst is executed.
- Full depth: addr=0, len=512, m_ready=1 -> 512 contiguous beats, m_last only on the beat from address 511, done after it.
